sha3_scan_controller: RTL

- Job-side front end that drives sha3_scanner and consumes its results.
- Accepts a 22-word job frame on a 32-bit valid/ready stream, then presents threshold and blobby to the scanner and pulses start.
- Tracks the scan through to completion, converts each capture into an absolute nonce plus difficulty hash word, and buffers results in a FIFO behind a valid/ready result stream.
- Sits between the AXI register/DMA layer and the scanner; targets PROPER scanner formulation only.

---
 rtl/sha3_ctl_pkg.sv | 25 ++
 rtl/sha3_result_fifo.sv | 71 +++++++
 rtl/sha3_scan_controller.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sha3_ctl_pkg.sv
// Shared definitions for the SHA-3 scan controller slice.
// Holds the job frame geometry, the controller state encoding and the
// result record that flows from scanner capture to the result stream.
package sha3_ctl_pkg;

    localparam int JOB_WORDS    = 22;
    localparam int BLOBBY_WORDS = 20;
    localparam int NONCE_WORD   = 19;
    localparam int HASH_WORDS   = 25;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SKIP  = 3'd2,
        ST_START = 3'd3,
        ST_ARM   = 3'd4,
        ST_SCAN  = 3'd5
    } ctl_state_t;

    typedef struct packed {
        logic [31:0] nonce;
        logic [63:0] hash;
    } result_t;

endpackage

// File: rtl/sha3_result_fifo.sv
// Synchronous result FIFO for the scan controller.
// Ports:
//   clk, rst       - clock and synchronous active-high reset (flushes)
//   push, push_data- write request and payload
//   pop            - read request; pop_data always shows the head entry
//   full, empty    - occupancy flags
// A push while full is still taken when a pop happens in the same cycle,
// because the pop frees the slot the push lands in.
module sha3_result_fifo
    import sha3_ctl_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = result_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping. DEPTH is a power of two so the
    // pointers wrap naturally; the extra count bit tells full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array. Stale contents are never visible because the flags
    // gate everything downstream, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sha3_scan_controller.sv
// Job-side front end for sha3_scanner.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   job_valid/ready/data/last      - 22-word job frame stream in
//   sc_start, sc_threshold,
//   sc_blobby                      - scanner launch pulse and job operands
//   sc_awaiting, sc_capture,
//   sc_nonce, sc_hash              - scanner status and capture results
//   res_valid/ready/nonce/hash     - buffered result stream out
//   busy, done, frame_err          - status (done/frame_err are pulses)
//   drop_count                     - saturating count of lost results
module sha3_scan_controller
    import sha3_ctl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int HASH_WORD  = 3,
    parameter int DROP_CNT_W = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               job_valid,
    output logic                               job_ready,
    input  logic [31:0]                        job_data,
    input  logic                               job_last,
    output logic                               sc_start,
    output logic [63:0]                        sc_threshold,
    output logic [BLOBBY_WORDS-1:0][31:0]      sc_blobby,
    input  logic                               sc_awaiting,
    input  logic                               sc_capture,
    input  logic [31:0]                        sc_nonce,
    input  logic [HASH_WORDS-1:0][63:0]        sc_hash,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [31:0]                        res_nonce,
    output logic [63:0]                        res_hash,
    output logic                               busy,
    output logic                               done,
    output logic                               frame_err,
    output logic [DROP_CNT_W-1:0]              drop_count
);

    localparam logic [4:0] LAST_IDX = 5'(JOB_WORDS - 1);

    ctl_state_t state;
    ctl_state_t next_state;
    logic [4:0] word_idx;
    logic       ready_state;
    logic       start_state;
    logic       err_set;
    logic       done_set;

    result_t    push_res;
    result_t    head_res;
    logic       fifo_full;
    logic       fifo_empty;
    logic       res_pop;
    logic       drop_event;
    logic       unused_hash;

    // Frame parsing and scan tracking. Words are only accepted in the
    // three frame-facing states, so the handshake reduces to job_valid.
    always_comb begin
        next_state  = state;
        ready_state = 1'b0;
        start_state = 1'b0;
        err_set     = 1'b0;
        done_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                ready_state = 1'b1;
                if (job_valid) begin
                    if (job_last) begin
                        err_set = 1'b1;
                    end else begin
                        next_state = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                ready_state = 1'b1;
                if (job_valid) begin
                    if (job_last) begin
                        if (word_idx == LAST_IDX) begin
                            next_state = ST_START;
                        end else begin
                            err_set    = 1'b1;
                            next_state = ST_IDLE;
                        end
                    end else if (word_idx == LAST_IDX) begin
                        err_set    = 1'b1;
                        next_state = ST_SKIP;
                    end
                end
            end
            ST_SKIP: begin
                ready_state = 1'b1;
                if (job_valid && job_last) begin
                    next_state = ST_IDLE;
                end
            end
            ST_START: begin
                start_state = 1'b1;
                next_state  = ST_ARM;
            end
            ST_ARM: begin
                if (sc_awaiting) begin
                    next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!sc_awaiting) begin
                    done_set   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs derived from the state are forced low while reset is held
    // so every output reads zero during reset, including a mid-start one.
    assign job_ready = ready_state && !rst;
    assign sc_start  = start_state && !rst;
    assign busy      = (state != ST_IDLE) && !rst;

    // State register, word counter and the registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            word_idx  <= '0;
            frame_err <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= next_state;
            frame_err <= err_set;
            done      <= done_set;
            if (state == ST_IDLE && job_valid && !job_last) begin
                word_idx <= 5'd1;
            end else if (state == ST_LOAD && job_valid) begin
                word_idx <= word_idx + 5'd1;
            end
        end
    end

    // Job operand registers feed the scanner directly. They change only
    // while a frame is loading, so they hold steady through the scan and
    // the start nonce stays valid for converting late captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_threshold <= '0;
            sc_blobby    <= '0;
        end else if (state == ST_IDLE && job_valid && !job_last) begin
            sc_threshold[31:0] <= job_data;
        end else if (state == ST_LOAD && job_valid) begin
            if (word_idx == 5'd1) begin
                sc_threshold[63:32] <= job_data;
            end else begin
                sc_blobby[word_idx - 5'd2] <= job_data;
            end
        end
    end

    // The scanner reports nonces relative to the start nonce; results are
    // made absolute here, wrapping modulo 2^32.
    assign push_res.nonce = sc_blobby[NONCE_WORD] + sc_nonce;
    assign push_res.hash  = sc_hash[HASH_WORD];
    assign unused_hash    = ^sc_hash;

    sha3_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (result_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sc_capture),
        .push_data (push_res),
        .pop       (res_pop),
        .pop_data  (head_res),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign res_valid  = !fifo_empty;
    assign res_pop    = res_valid && res_ready;
    assign res_nonce  = res_valid ? head_res.nonce : '0;
    assign res_hash   = res_valid ? head_res.hash  : '0;
    assign drop_event = sc_capture && fifo_full && !res_pop;

    // Lost-result counter: sticks at all-ones and clears only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop_event && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end

endmodule
